// File: rtl/dff_write_arbiter_if.sv
// Requester-facing bus of the shared q/qb write arbiter.
// With DFF_ARB_PARITY_EN defined, the bus also carries q_par.
interface dff_write_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
);
    localparam int IW = $clog2(N_REQ);

    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] wdata;
    logic [N_REQ-1:0]       ack;
    logic [IW-1:0]          grant_id;
    logic [WIDTH-1:0]       q;
    logic [WIDTH-1:0]       qb;
    logic                   busy;
    logic [15:0]            wr_count;
`ifdef DFF_ARB_PARITY_EN
    logic                   q_par;
`endif

    modport master (
        output req, wdata,
        input  ack, grant_id, q, qb, busy, wr_count
`ifdef DFF_ARB_PARITY_EN
        , input q_par
`endif
    );

    modport slave (
        input  req, wdata,
        output ack, grant_id, q, qb, busy, wr_count
`ifdef DFF_ARB_PARITY_EN
        , output q_par
`endif
    );
endinterface

// File: rtl/dff_write_arbiter.sv
// Round-robin write arbiter for a shared WIDTH-bit q/qb register with idle gap.
// Optional registered even parity of q when DFF_ARB_PARITY_EN is defined.
module dff_write_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int GAP   = 2
) (
    input logic            clk,
    input logic            rst,
    dff_write_arbiter_if.slave bus
);
    localparam int IW = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, WRITE, COOL} state_t;

    state_t           state;
    logic [IW-1:0]    ptr;
    logic [IW-1:0]    gid;
    logic [IW-1:0]    sel;
    logic             sel_vld;
    logic [3:0]       cnt;
    logic [N_REQ-1:0] ack;
    logic [N_REQ-1:0] eff;
    logic [WIDTH-1:0] q;
    logic [15:0]      wr_count;
    logic [WIDTH-1:0] wslice;

    // The requester acked this cycle still has req high; mask it so GAP=0 cannot double-grant.
    assign eff    = bus.req & ~ack;
    assign wslice = bus.wdata[gid*WIDTH +: WIDTH];

    // Walk downward so the candidate closest to ptr is the last (winning) assignment.
    always_comb begin
        sel     = '0;
        sel_vld = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (eff[(int'(ptr) + k) % N_REQ]) begin
                sel     = IW'((int'(ptr) + k) % N_REQ);
                sel_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            gid      <= '0;
            cnt      <= '0;
            ack      <= '0;
            q        <= '0;
            wr_count <= '0;
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    if (sel_vld) begin
                        gid   <= sel;
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    q   <= wslice;
                    ack <= N_REQ'(1) << gid;
                    ptr <= (gid == IW'(N_REQ - 1)) ? '0 : gid + 1'b1;
                    if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
                    if (GAP > 0) begin
                        cnt   <= 4'(GAP);
                        state <= COOL;
                    end else begin
                        state <= IDLE;
                    end
                end
                COOL: begin
                    cnt <= cnt - 4'd1;
                    if (cnt <= 4'd1) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DFF_ARB_PARITY_EN
    logic q_par;
    always_ff @(posedge clk) begin
        if (rst)                q_par <= 1'b0;
        else if (state == WRITE) q_par <= ^wslice;
    end
    assign bus.q_par = q_par;
`endif

    assign bus.ack      = ack;
    assign bus.grant_id = gid;
    assign bus.q        = q;
    assign bus.qb       = ~q;
    assign bus.busy     = (state != IDLE);
    assign bus.wr_count = wr_count;
endmodule
